// File: rtl/gtfraw_vnc_freq_mon_pkg.sv
// Shared types and helpers for the gtfraw_vnc frequency monitor controller.
package gtfraw_vnc_freq_mon_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EDGE,
        SETTLE,
        SELECT,
        CAPTURE
    } state_t;

    // Mux select width: at least one bit even for a single channel.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gtfraw_vnc_period_timer.sv
// Free-running measurement period counter; tc marks the last tick of each period.
module gtfraw_vnc_period_timer #(
    parameter int PERIOD_TICKS = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tc
);

    localparam int TW = $clog2(PERIOD_TICKS + 1);

    logic [TW-1:0] count;

    assign tc = enable && (count == TW'(PERIOD_TICKS - 1));

    // Count 0..PERIOD_TICKS-1 while enabled, hold at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gtfraw_vnc_freq_monitor_ctrl.sv
// Scheduler for a bank of clock counters: toggles the shared one-second edge,
// waits for the counters to settle, reads each through an external mux and
// checks the reading against a per-channel window with sticky alarms.
module gtfraw_vnc_freq_monitor_ctrl
    import gtfraw_vnc_freq_mon_pkg::*;
#(
    parameter int NUM_CLKS         = 4,
    parameter int PERIOD_TICKS     = 100_000_000,
    parameter int SETTLE_CYCLES    = 64,
    parameter int SEL_WAIT         = 2,
    parameter bit SKIP_PARAM_CHECK = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          alarm_clr,
    input  logic [NUM_CLKS*CNT_W-1:0]     exp_min,
    input  logic [NUM_CLKS*CNT_W-1:0]     exp_max,
    input  logic [CNT_W-1:0]              cnt_value,
    output logic                          one_second_edge,
    output logic [sel_w(NUM_CLKS)-1:0]    cnt_sel,
    output logic [NUM_CLKS*CNT_W-1:0]     freq_snap,
    output logic [NUM_CLKS-1:0]           alarm,
    output logic                          overrun,
    output logic                          meas_done,
    output logic                          busy
);

    localparam int SW = sel_w(NUM_CLKS);

    if (!SKIP_PARAM_CHECK &&
        PERIOD_TICKS <= SETTLE_CYCLES + NUM_CLKS * (SEL_WAIT + 1) + 2) begin : g_bad_period
        $error("PERIOD_TICKS too short for the read sequence");
    end
    if (NUM_CLKS < 1 || NUM_CLKS > 16) begin : g_bad_num_clks
        $error("NUM_CLKS must be within 1..16");
    end

    state_t                      state, state_nxt;
    logic                        first, first_nxt;
    logic [SW-1:0]               ch, ch_nxt;
    logic [31:0]                 wait_cnt, wait_nxt;
    logic                        edge_nxt;
    logic [NUM_CLKS*CNT_W-1:0]   snap_nxt;
    logic [NUM_CLKS-1:0]         alarm_set;
    logic                        ovr_set;
    logic                        done_nxt;
    logic [CNT_W-1:0]            cur_min, cur_max;
    logic                        tc;

    gtfraw_vnc_period_timer #(
        .PERIOD_TICKS(PERIOD_TICKS)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tc     (tc)
    );

    assign busy    = (state == SETTLE) || (state == SELECT) || (state == CAPTURE);
    assign cnt_sel = ch;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            first           <= 1'b1;
            ch              <= '0;
            wait_cnt        <= '0;
            one_second_edge <= 1'b0;
            freq_snap       <= '0;
            alarm           <= '0;
            overrun         <= 1'b0;
            meas_done       <= 1'b0;
        end else begin
            state           <= state_nxt;
            first           <= first_nxt;
            ch              <= ch_nxt;
            wait_cnt        <= wait_nxt;
            one_second_edge <= edge_nxt;
            freq_snap       <= snap_nxt;
            alarm           <= (alarm & ~{NUM_CLKS{alarm_clr}}) | alarm_set;
            overrun         <= (overrun & ~alarm_clr) | ovr_set;
            meas_done       <= done_nxt;
        end
    end

    // Next-state, capture and window compare.
    always_comb begin
        state_nxt = state;
        first_nxt = first;
        ch_nxt    = ch;
        wait_nxt  = '0;
        snap_nxt  = freq_snap;
        alarm_set = '0;
        ovr_set   = 1'b0;
        done_nxt  = 1'b0;
        edge_nxt  = one_second_edge ^ tc;
        cur_min   = exp_min[CNT_W*int'(ch) +: CNT_W];
        cur_max   = exp_max[CNT_W*int'(ch) +: CNT_W];

        if (!enable) begin
            state_nxt = IDLE;
            first_nxt = 1'b1;
        end else if (tc && busy) begin
            // Period ended mid-sequence: restart reading against the new edge.
            ovr_set   = 1'b1;
            state_nxt = SETTLE;
            ch_nxt    = '0;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_EDGE;
                WAIT_EDGE: begin
                    if (tc) begin
                        if (first) begin
                            first_nxt = 1'b0;
                        end else begin
                            state_nxt = SETTLE;
                            ch_nxt    = '0;
                        end
                    end
                end
                SETTLE: begin
                    if (wait_cnt == 32'(SETTLE_CYCLES - 1)) begin
                        state_nxt = SELECT;
                    end else begin
                        wait_nxt = wait_cnt + 32'd1;
                    end
                end
                SELECT: begin
                    if (wait_cnt == 32'(SEL_WAIT - 1)) begin
                        state_nxt = CAPTURE;
                    end else begin
                        wait_nxt = wait_cnt + 32'd1;
                    end
                end
                CAPTURE: begin
                    snap_nxt[CNT_W*int'(ch) +: CNT_W] = cnt_value;
                    if (cnt_value < cur_min || cnt_value > cur_max) begin
                        alarm_set[ch] = 1'b1;
                    end
                    if (ch == SW'(NUM_CLKS - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = WAIT_EDGE;
                    end else begin
                        ch_nxt    = ch + 1'b1;
                        state_nxt = SELECT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gtfraw_vnc_freq_monitor_ctrl.sv
// Randomised bench for the frequency monitor controller with a timeline model.
module tb_gtfraw_vnc_freq_monitor_ctrl;

    localparam int N = 2;
    localparam int P = 200;
    localparam int S = 8;
    localparam int W = 2;
    localparam int L = S + N * (W + 1);

    logic          clk = 1'b0;
    logic          reset, enable, alarm_clr;
    logic [63:0]   exp_min, exp_max;
    logic [31:0]   cnt_value;
    logic [31:0]   chan_val [N];
    logic          sec_edge, overrun, meas_done, busy;
    logic [0:0]    cnt_sel;
    logic [63:0]   freq_snap;
    logic [1:0]    alarm;

    logic          en2;
    logic          sec_edge2, overrun2, meas_done2, busy2;
    logic [0:0]    cnt_sel2;
    logic [63:0]   freq_snap2;
    logic [1:0]    alarm2;

    int vectors = 0;
    int miscompares = 0;
    int n_done2 = 0;

    always #5 clk = ~clk;

    // External counter mux.
    always_comb cnt_value = chan_val[cnt_sel];

    gtfraw_vnc_freq_monitor_ctrl #(
        .NUM_CLKS(N), .PERIOD_TICKS(P), .SETTLE_CYCLES(S), .SEL_WAIT(W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .alarm_clr(alarm_clr),
        .exp_min(exp_min), .exp_max(exp_max), .cnt_value(cnt_value),
        .one_second_edge(sec_edge), .cnt_sel(cnt_sel), .freq_snap(freq_snap),
        .alarm(alarm), .overrun(overrun), .meas_done(meas_done), .busy(busy)
    );

    gtfraw_vnc_freq_monitor_ctrl #(
        .NUM_CLKS(N), .PERIOD_TICKS(20), .SETTLE_CYCLES(16), .SEL_WAIT(W),
        .SKIP_PARAM_CHECK(1'b1)
    ) dut_ovr (
        .clk(clk), .reset(reset), .enable(en2), .alarm_clr(1'b0),
        .exp_min(64'd0), .exp_max({2{32'hFFFF_FFFF}}), .cnt_value(32'd5),
        .one_second_edge(sec_edge2), .cnt_sel(cnt_sel2), .freq_snap(freq_snap2),
        .alarm(alarm2), .overrun(overrun2), .meas_done(meas_done2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Timeline model: enabled-edge count k gives the period position; "since"
    // counts edges after a non-first edge toggle and locates each read slot.
    int               m_k, m_since;
    bit               m_seq, m_edge, m_ovr, m_done;
    logic [31:0]      m_snap [N];
    logic [N-1:0]     m_alarm;
    logic [N-1:0]     m_set;
    bit               m_oset, m_tc, m_busy;
    int               m_j, m_c;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k = 0; m_since = 0; m_seq = 0; m_edge = 0; m_ovr = 0; m_done = 0;
            m_alarm = '0;
            for (int i = 0; i < N; i++) m_snap[i] = '0;
        end else begin
            m_set = '0;
            m_oset = 0;
            m_done = 0;
            if (!enable) begin
                m_k = 0;
                m_seq = 0;
            end else begin
                m_tc = (m_k % P) == P - 1;
                m_busy = m_seq && m_since < L;
                if (m_tc) begin
                    m_edge = ~m_edge;
                    if (m_k >= P) begin
                        if (m_busy) m_oset = 1;
                        m_seq = 1;
                        m_since = 0;
                    end
                end else begin
                    if (m_busy && m_since >= S) begin
                        m_j = m_since - S;
                        m_c = m_j / (W + 1);
                        if (m_j % (W + 1) == W) begin
                            m_snap[m_c] = chan_val[m_c];
                            if (chan_val[m_c] < exp_min[32*m_c +: 32] ||
                                chan_val[m_c] > exp_max[32*m_c +: 32])
                                m_set[m_c] = 1'b1;
                            if (m_c == N - 1) m_done = 1;
                        end
                    end
                    if (m_busy) m_since++;
                end
                m_k++;
            end
            m_alarm = (m_alarm & ~{N{alarm_clr}}) | m_set;
            m_ovr = (m_ovr & ~alarm_clr) | m_oset;
        end
    end

    function automatic bit model_busy();
        return m_seq && m_since < L;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("edge", 64'(sec_edge), 64'(m_edge));
            chk("busy", 64'(busy), 64'(model_busy()));
            chk("meas_done", 64'(meas_done), 64'(m_done));
            chk("alarm", 64'(alarm), 64'(m_alarm));
            chk("overrun", 64'(overrun), 64'(m_ovr));
            chk("freq_snap", freq_snap, {m_snap[1], m_snap[0]});
            if (model_busy() && m_since >= S)
                chk("cnt_sel", 64'(cnt_sel), 64'((m_since - S) / (W + 1)));
            if (meas_done2) n_done2++;
        end
    end

    task automatic wait_toggle(output int n);
        logic prev;
        prev = sec_edge;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sec_edge == prev && n < 1000);
        if (sec_edge == prev) timeout("wait_toggle");
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!meas_done && n < 1000);
        if (!meas_done) timeout("wait_done");
    endtask

    task automatic set_win(input logic [31:0] lo, input logic [31:0] hi);
        exp_min = {lo, lo};
        exp_max = {hi, hi};
    endtask

    int           n;
    logic [63:0]  saved_snap;
    logic         saved_edge, prev_e;
    logic [31:0]  lo;

    initial begin
        reset = 1; enable = 0; alarm_clr = 0; en2 = 0;
        set_win(100, 200);
        chan_val[0] = 150; chan_val[1] = 150;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_edge", 64'(sec_edge), 0);
        chk("rst_sel", 64'(cnt_sel), 0);
        chk("rst_snap", freq_snap, 0);
        chk("rst_alarm", 64'(alarm), 0);
        chk("rst_ovr", 64'(overrun), 0);
        chk("rst_done", 64'(meas_done), 0);
        chk("rst_busy", 64'(busy), 0);

        // First period is discarded.
        enable = 1;
        wait_toggle(n);
        chk("first_toggle_cycle", 64'(n), 200);
        chk("first_period_busy", 64'(busy), 0);

        // In-window read.
        wait_toggle(n);
        chk("second_toggle_cycle", 64'(n), 200);
        wait_done(n);
        chk("done_latency", 64'(n), 14);
        chk("snap_150", freq_snap, {32'd150, 32'd150});
        chk("alarm_in_window", 64'(alarm), 0);

        // Degenerate window boundaries.
        set_win(150, 150);
        chan_val[0] = 151; chan_val[1] = 150;
        wait_toggle(n);
        wait_done(n);
        chk("alarm_boundary", 64'(alarm), 2'b01);

        alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        @(negedge clk);
        chk("idle_clr_alarm", 64'(alarm), 0);
        chk("idle_clr_ovr", 64'(overrun), 0);

        set_win(100, 200);
        chan_val[0] = 99;
        wait_toggle(n);
        wait_done(n);
        chk("alarm_below_min", 64'(alarm), 2'b01);

        alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        // Clear during the alarm-setting capture of channel 0.
        wait_toggle(n);
        repeat (S + W) @(negedge clk);
        alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        chk("set_beats_clr", 64'(alarm[0]), 1);
        wait_done(n);

        // Randomised periods, with an enable drop during SELECT.
        for (int it = 0; it < 8; it++) begin
            n = 0;
            prev_e = sec_edge;
            while (n < 1000 && sec_edge == prev_e) begin
                @(negedge clk);
                n++;
                alarm_clr = ($urandom_range(0, 19) == 0);
                if (!model_busy() && sec_edge == prev_e) begin
                    lo = $urandom_range(80, 150);
                    exp_min = {32'($urandom_range(80, 150)), lo};
                    exp_max = {32'($urandom_range(150, 220)), lo + 32'($urandom_range(0, 60))};
                    chan_val[0] = $urandom_range(60, 230);
                    chan_val[1] = $urandom_range(60, 230);
                end
            end
            alarm_clr = 0;
            if (sec_edge == prev_e) timeout("rand_toggle");
            if (it == 5) chk("restart_first_discarded", 64'(busy), 0);
            if (it == 4) begin
                repeat (S + 1) @(negedge clk);
                chk("drop_in_select", 64'(busy), 1);
                saved_snap = freq_snap;
                saved_edge = sec_edge;
                enable = 0;
                @(negedge clk);
                chk("drop_idle", 64'(busy), 0);
                chk("drop_edge_held", 64'(sec_edge), 64'(saved_edge));
                chk("drop_snap_kept", freq_snap, saved_snap);
                repeat (3) @(negedge clk);
                enable = 1;
            end
        end

        // Overrun on the short-period instance.
        en2 = 1;
        repeat (40) @(negedge clk);
        chk("ovr_not_yet", 64'(overrun2), 0);
        chk("ovr_busy_2nd", 64'(busy2), 1);
        repeat (20) @(negedge clk);
        chk("ovr_set", 64'(overrun2), 1);
        chk("ovr_resettle_busy", 64'(busy2), 1);
        chk("ovr_resettle_sel", 64'(cnt_sel2), 0);
        chk("ovr_edge", 64'(sec_edge2), 1);
        repeat (15) @(negedge clk);
        chk("ovr_no_done", 64'(n_done2), 0);

        // Asynchronous reset in the middle of a capture.
        wait_toggle(n);
        repeat (S + W) @(negedge clk);
        chan_val[0] = 7;
        #1 reset = 1;
        #1;
        chk("mid_rst_edge", 64'(sec_edge), 0);
        chk("mid_rst_sel", 64'(cnt_sel), 0);
        chk("mid_rst_snap", freq_snap, 0);
        chk("mid_rst_alarm", 64'(alarm), 0);
        chk("mid_rst_ovr", 64'(overrun), 0);
        chk("mid_rst_done", 64'(meas_done), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_ovr2", 64'(overrun2), 0);
        @(negedge clk);
        reset = 0;
        enable = 0;
        en2 = 0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
